// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate
// formats and the per-instruction control bundle used by the ID stage.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7,
      ALU_SRA = 4'd8
   } alu_op_e;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_S    = 2'd2,
      IMM_B    = 2'd3
   } imm_type_e;

   // Decoded control for one instruction before it is registered.
   typedef struct packed {
      logic      reg_write;
      logic      mem_read;
      logic      mem_write;
      logic      branch;
      logic      alu_src;
      alu_op_e   alu_op;
      imm_type_e imm_type;
      logic      rs2_used;
      logic      rd_used;
   } ctrl_t;

   // ALU operation from funct3 / funct7[5]. SUB only exists in the
   // register form; SLTU/SLTIU fold onto SLT as the ALU has no unsigned
   // compare.
   function automatic alu_op_e alu_dec(input logic [2:0] f3,
                                       input logic       f7b5,
                                       input logic       is_r);
      alu_op_e op;
      case (f3)
         3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: extracts the I/S/B immediate and sign-extends it.
module imm_gen
   import rv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [31:0]  i_instr,
   input  imm_type_e    i_imm_type,
   output logic [N-1:0] o_imm
);

   logic [12:0] w_imm13;
   logic        w_unused;

   // Collect the raw immediate as a 13-bit signed value (B is the widest).
   always_comb begin
      w_imm13 = '0;
      case (i_imm_type)
         IMM_I:   w_imm13 = {i_instr[31], i_instr[31:20]};
         IMM_S:   w_imm13 = {i_instr[31], i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_imm13 = {i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
         default: w_imm13 = '0;
      endcase
   end

   assign o_imm    = {{(N-13){w_imm13[12]}}, w_imm13};
   // Opcode, rs1 and funct3 never contribute to an immediate.
   assign w_unused = ^{i_instr[19:12], i_instr[6:0]};

endmodule

// File: rtl/id_ex_stage.sv
// ID stage: decode, register-file read with write-back bypass, load-use
// hazard detection and the ID/EX pipeline register.
module id_ex_stage
   import rv_pkg::*;
#(
   parameter int N   = 32,
   parameter int PCW = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   input  logic [31:0]    id_instr,
   input  logic [PCW-1:0] id_pc,
   input  logic           flush,
   output logic [4:0]     readreg1,
   output logic [4:0]     readreg2,
   input  logic [N-1:0]   regdata1,
   input  logic [N-1:0]   regdata2,
   input  logic           wb_rw,
   input  logic [4:0]     wb_writereg,
   input  logic [N-1:0]   wb_data,
   output logic           stall,
   output logic           ex_valid,
   output logic           ex_reg_write,
   output logic           ex_mem_read,
   output logic           ex_mem_write,
   output logic           ex_branch,
   output logic           ex_alu_src,
   output logic [3:0]     ex_alu_op,
   output logic [4:0]     ex_rd,
   output logic [N-1:0]   ex_rs1_data,
   output logic [N-1:0]   ex_rs2_data,
   output logic [N-1:0]   ex_imm,
   output logic [PCW-1:0] ex_pc
);

   logic [6:0]     w_opcode;
   logic [4:0]     w_rd;
   logic [4:0]     w_rs1;
   logic [4:0]     w_rs2;
   ctrl_t          w_ctrl;
   logic [N-1:0]   w_imm;
   logic [N-1:0]   w_op1;
   logic [N-1:0]   w_op2;
   logic           w_hazard;
   logic           w_bubble;

   logic           r_valid;
   logic           r_reg_write;
   logic           r_mem_read;
   logic           r_mem_write;
   logic           r_branch;
   logic           r_alu_src;
   logic [3:0]     r_alu_op;
   logic [4:0]     r_rd;
   logic [N-1:0]   r_rs1_data;
   logic [N-1:0]   r_rs2_data;
   logic [N-1:0]   r_imm;
   logic [PCW-1:0] r_pc;

   assign w_opcode = id_instr[6:0];
   assign w_rd     = id_instr[11:7];
   assign w_rs1    = id_instr[19:15];
   assign w_rs2    = id_instr[24:20];
   assign readreg1 = w_rs1;
   assign readreg2 = w_rs2;

   // Opcode decode into the control bundle; unknown opcodes stay all-zero.
   always_comb begin
      w_ctrl          = '0;
      w_ctrl.alu_op   = ALU_ADD;
      w_ctrl.imm_type = IMM_NONE;
      case (w_opcode)
         OP_R: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.rd_used   = 1'b1;
            w_ctrl.rs2_used  = 1'b1;
            w_ctrl.alu_op    = alu_dec(id_instr[14:12], id_instr[30], 1'b1);
         end
         OP_I: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.rd_used   = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.imm_type  = IMM_I;
            w_ctrl.alu_op    = alu_dec(id_instr[14:12], id_instr[30], 1'b0);
         end
         OP_LOAD: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.rd_used   = 1'b1;
            w_ctrl.mem_read  = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.imm_type  = IMM_I;
         end
         OP_STORE: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.rs2_used  = 1'b1;
            w_ctrl.imm_type  = IMM_S;
         end
         OP_BRANCH: begin
            w_ctrl.branch   = 1'b1;
            w_ctrl.rs2_used = 1'b1;
            w_ctrl.alu_op   = ALU_SUB;
            w_ctrl.imm_type = IMM_B;
         end
         default: ;
      endcase
      // x0 is hardwired; never let a write to it reach WB.
      if (w_rd == 5'd0) w_ctrl.reg_write = 1'b0;
   end

   imm_gen #(.N(N)) u_imm_gen (
      .i_instr    (id_instr),
      .i_imm_type (w_ctrl.imm_type),
      .o_imm      (w_imm)
   );

   // Operands: x0 reads zero, a same-cycle WB write to the source wins.
   assign w_op1 = (w_rs1 == 5'd0) ? '0 :
                  (wb_rw && (wb_writereg == w_rs1)) ? wb_data : regdata1;
   assign w_op2 = (w_rs2 == 5'd0) ? '0 :
                  (wb_rw && (wb_writereg == w_rs2)) ? wb_data : regdata2;

   // Load in EX whose result is needed by the instruction now in ID.
   assign w_hazard = r_valid && r_mem_read && (r_rd != 5'd0) &&
                     ((r_rd == w_rs1) || (w_ctrl.rs2_used && (r_rd == w_rs2)));
   assign stall    = !rst && id_valid && w_hazard && !flush;
   assign w_bubble = flush || !id_valid || stall;

   // ID/EX register: clear on reset, bubble on flush/empty/stall, else load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= 1'b0;
         r_alu_src   <= 1'b0;
         r_alu_op    <= '0;
         r_rd        <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_pc        <= '0;
      end else if (w_bubble) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= 1'b0;
         r_alu_src   <= 1'b0;
         r_alu_op    <= '0;
         r_rd        <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_pc        <= '0;
      end else begin
         r_valid     <= 1'b1;
         r_reg_write <= w_ctrl.reg_write;
         r_mem_read  <= w_ctrl.mem_read;
         r_mem_write <= w_ctrl.mem_write;
         r_branch    <= w_ctrl.branch;
         r_alu_src   <= w_ctrl.alu_src;
         r_alu_op    <= w_ctrl.alu_op;
         r_rd        <= w_ctrl.rd_used ? w_rd : 5'd0;
         r_rs1_data  <= w_op1;
         r_rs2_data  <= w_op2;
         r_imm       <= w_imm;
         r_pc        <= id_pc;
      end
   end

   assign ex_valid     = r_valid;
   assign ex_reg_write = r_reg_write;
   assign ex_mem_read  = r_mem_read;
   assign ex_mem_write = r_mem_write;
   assign ex_branch    = r_branch;
   assign ex_alu_src   = r_alu_src;
   assign ex_alu_op    = r_alu_op;
   assign ex_rd        = r_rd;
   assign ex_rs1_data  = r_rs1_data;
   assign ex_rs2_data  = r_rs2_data;
   assign ex_imm       = r_imm;
   assign ex_pc        = r_pc;

endmodule
